axi_line_reader: RTL and testbench

AXI_LINE_READER -- requirements
Module: axi_line_reader

---
 rtl/axi_line_reader_pkg.sv | 14 +
 rtl/axi_line_reader_burst_calc.sv | 24 ++
 rtl/axi_line_reader.sv | 96 +++++++++
 tb/tb_axi_line_reader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_line_reader_pkg.sv
// axi_line_reader_pkg: shared FSM encoding and AXI constants for the line reader
package axi_line_reader_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    localparam int PAGE_BYTES = 4096;

endpackage

// File: rtl/axi_line_reader_burst_calc.sv
// axi_burst_calc: beats for the next burst = min(remaining, MAX_BEATS, words left in the 4 KB page)
module axi_burst_calc
    import axi_line_reader_pkg::*;
#(
    parameter int MAX_BEATS = 256
) (
    input  logic [31:0] remaining_i,
    input  logic [11:0] page_off_i,
    output logic [8:0]  beats_o
);

    logic [10:0] room;
    logic [10:0] rem_cap;
    logic [10:0] lim;
    logic [10:0] b;

    // Word-aligned offsets give 1..1024 words of room; anything past 1024 remaining is capped anyway
    assign room    = 11'((13'(PAGE_BYTES) - {1'b0, page_off_i}) >> 2);
    assign rem_cap = (|remaining_i[31:11]) ? 11'd1024 : remaining_i[10:0];
    assign lim     = (rem_cap < room) ? rem_cap : room;
    assign b       = (lim < 11'(MAX_BEATS)) ? lim : 11'(MAX_BEATS);
    assign beats_o = 9'(b);

endmodule

// File: rtl/axi_line_reader.sv
// axi_line_reader: fetches one line of 32-bit words over AXI4 read bursts into the display FIFO
module axi_line_reader
    import axi_line_reader_pkg::*;
#(
    parameter int MAX_BEATS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        kick,
    input  logic [31:0] read_addr,
    input  logic [31:0] read_num,
    output logic        busy,
    output logic        err,
    output logic [31:0] m_araddr,
    output logic [7:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic [1:0]  m_arburst,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rlast,
    input  logic        m_rvalid,
    output logic        m_rready,
    output logic [31:0] buf_dout,
    output logic        buf_we
);

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rem_q, rem_d;
    logic        err_q, err_d;
    logic        we_q;
    logic [31:0] dout_q;
    logic [8:0]  beats;
    logic        beat;

    axi_burst_calc #(.MAX_BEATS(MAX_BEATS)) u_calc (
        .remaining_i(rem_q),
        .page_off_i (addr_q[11:0]),
        .beats_o    (beats)
    );

    assign beat      = m_rvalid && (state_q == ST_DATA);
    assign busy      = state_q != ST_IDLE;
    assign err       = err_q;
    assign m_araddr  = addr_q;
    assign m_arvalid = state_q == ST_ADDR;
    assign m_arlen   = m_arvalid ? 8'(beats - 9'd1) : 8'd0;
    assign m_arsize  = SIZE_4B;
    assign m_arburst = BURST_INCR;
    assign m_rready  = state_q == ST_DATA;
    assign buf_we    = we_q;
    assign buf_dout  = dout_q;

    // Next state: accept a line in IDLE, one burst in flight, re-issue or finish on rlast
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        err_d   = err_q;
        if (state_q == ST_IDLE && kick && read_num != 32'd0) begin
            state_d = ST_ADDR;
            addr_d  = read_addr & ~32'd3;
            rem_d   = read_num;
            err_d   = 1'b0;
        end
        if (state_q == ST_ADDR && m_arready) state_d = ST_DATA;
        if (beat) begin
            addr_d = addr_q + 32'd4;
            rem_d  = rem_q - 32'd1;
            err_d  = err_q | (m_rresp != RESP_OKAY);
            if (m_rlast) state_d = (rem_q == 32'd1) ? ST_IDLE : ST_ADDR;
        end
    end

    // State registers and the registered pixel-word output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            we_q    <= beat;
            if (beat) dout_q <= m_rdata;
        end
    end

endmodule

// File: tb/tb_axi_line_reader.sv
// tb_axi_line_reader: randomized AXI slave plus line-level reference model for axi_line_reader
module tb_axi_line_reader;

    localparam int MAXB = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        kick;
    logic [31:0] read_addr, read_num;
    logic        busy, err;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_arvalid, m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast, m_rvalid, m_rready;
    logic [31:0] buf_dout;
    logic        buf_we;

    axi_line_reader #(.MAX_BEATS(MAXB)) dut (
        .clk(clk), .rst_n(rst_n), .kick(kick), .read_addr(read_addr), .read_num(read_num),
        .busy(busy), .err(err),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .buf_dout(buf_dout), .buf_we(buf_we)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  l;
    } ar_t;

    ar_t         exp_ar[$];
    logic [31:0] exp_data[$];
    ar_t         e;
    int          n_chk = 0, n_pass = 0;
    logic [31:0] salt = 32'h0;
    bit          full = 1'b1;
    int          stall = 0, bad_beat = 0;
    int          w_idx = 0, we_idx = 0, ar_cnt = 0, we_cnt = 0;
    int          bl = 0;
    logic [31:0] baddr = 32'h0;
    logic        ar_v = 1'b0, rr = 1'b0;
    logic [31:0] ar_a = 32'h0;
    logic [7:0]  ar_l = 8'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    endtask

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    // Line-level model: split into page-safe bursts and list the words the FIFO must receive
    task automatic plan(input logic [31:0] a, input int n, output int nb);
        logic [31:0] cur = a & ~32'd3;
        int rem = n;
        nb = 0;
        while (rem > 0) begin
            int room = (4096 - int'(cur[11:0])) / 4;
            int b = rem;
            if (MAXB < b) b = MAXB;
            if (room < b) b = room;
            exp_ar.push_back('{cur, 8'(b - 1)});
            for (int j = 0; j < b; j++) exp_data.push_back(hash(cur + 32'(4 * j)));
            cur += 32'(4 * b);
            rem -= b;
            nb++;
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_arvalid"}, 32'(m_arvalid), 32'd0);
        chk({tag, "_rready"}, 32'(m_rready), 32'd0);
        chk({tag, "_we"}, 32'(buf_we), 32'd0);
        chk({tag, "_araddr"}, m_araddr, 32'd0);
        chk({tag, "_arlen"}, 32'(m_arlen), 32'd0);
        chk({tag, "_dout"}, buf_dout, 32'd0);
    endtask

    task automatic start_line(input logic [31:0] a, input int n, input bit f, input int st, input int bad, output int nb);
        salt = $urandom;
        full = f;
        stall = st;
        bad_beat = bad;
        w_idx = 0;
        we_idx = 0;
        ar_cnt = 0;
        we_cnt = 0;
        exp_ar.delete();
        exp_data.delete();
        plan(a, n, nb);
        read_addr = a;
        read_num = 32'(n);
        kick = 1'b1;
        @(negedge clk);
        kick = 1'b0;
        read_addr = $urandom;
        read_num = $urandom;
        chk("busy_on", 32'(busy), 32'd1);
        chk("err_clr", 32'(err), 32'd0);
    endtask

    task automatic run_line(input logic [31:0] a, input int n, input bit f, input int st, input int bad, input bit mid);
        int nb, t;
        logic [31:0] cap_a;
        logic [7:0] cap_l;
        start_line(a, n, f, st, bad, nb);
        if (st > 0) begin
            chk("stall_arvalid0", 32'(m_arvalid), 32'd1);
            cap_a = m_araddr;
            cap_l = m_arlen;
            repeat (8) begin
                @(negedge clk);
                chk("stall_arvalid", 32'(m_arvalid), 32'd1);
                chk("stall_araddr", m_araddr, cap_a);
                chk("stall_arlen", 32'(m_arlen), 32'(cap_l));
            end
        end
        t = 0;
        while (busy && t < n * 12 + 200) begin
            kick = mid && (t == 3);
            if (kick) begin
                read_num = 32'd5;
                read_addr = $urandom;
            end
            @(negedge clk);
            t++;
        end
        kick = 1'b0;
        if (busy) chk("timeout", 32'd1, 32'd0);
        else chk("last_we", 32'(buf_we), 32'd1);
        @(negedge clk);
        #1;
        chk("bursts", 32'(ar_cnt), 32'(nb));
        chk("we_cnt", 32'(we_cnt), 32'(n));
        chk("q_empty", 32'(exp_data.size()), 32'd0);
        chk("err_end", 32'(err), 32'(bad != 0));
    endtask

    // AXI slave and FIFO monitor; handshakes are judged from values sampled on the previous falling edge
    initial begin
        m_arready = 1'b0;
        m_rvalid = 1'b0;
        m_rdata = 32'h0;
        m_rresp = 2'b00;
        m_rlast = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_arready = 1'b0;
                m_rvalid = 1'b0;
                m_rlast = 1'b0;
                ar_v = 1'b0;
                rr = 1'b0;
                bl = 0;
            end else begin
                if (rr && m_rvalid) begin
                    bl--;
                    baddr += 32'd4;
                    w_idx++;
                end
                if (ar_v && m_arready) begin
                    ar_cnt++;
                    if (exp_ar.size() == 0) chk("ar_extra", 32'd1, 32'd0);
                    else begin
                        e = exp_ar.pop_front();
                        chk("araddr", ar_a, e.a);
                        chk("arlen", 32'(ar_l), 32'(e.l));
                    end
                    bl = int'(ar_l) + 1;
                    baddr = ar_a;
                end
                if (buf_we) begin
                    we_cnt++;
                    if (exp_data.size() == 0) chk("we_extra", 32'd1, 32'd0);
                    else begin
                        we_idx++;
                        chk("dout", buf_dout, exp_data.pop_front());
                        chk("err_run", 32'(err), 32'(bad_beat != 0 && we_idx >= bad_beat));
                    end
                end
                m_arready = (stall > 0) ? 1'b0 : (full || $urandom_range(0, 2) != 0);
                if (stall > 0 && m_arvalid) stall--;
                m_rvalid = bl > 0 && (full || $urandom_range(0, 3) != 0);
                m_rdata = hash(baddr);
                m_rlast = bl == 1;
                m_rresp = (bad_beat == w_idx + 1) ? 2'b10 : 2'b00;
                ar_v = m_arvalid;
                ar_a = m_araddr;
                ar_l = m_arlen;
                rr = m_rready;
            end
        end
    end

    initial begin
        int nb, t;
        rst_n = 1'b0;
        kick = 1'b0;
        read_addr = 32'h0;
        read_num = 32'h0;
        repeat (3) @(negedge clk);
        chk_rst("rst");
        chk("arsize", 32'(m_arsize), 32'd2);
        chk("arburst", 32'(m_arburst), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_line(32'h1000_0000, 1280, 1'b1, 0, 0, 1'b0);
        run_line(32'h0000_0FF0, 8, 1'b1, 0, 0, 1'b0);
        run_line(32'hFFFF_FFF2, 8, 1'b0, 0, 0, 1'b0);
        run_line(32'h0000_3F00, 100, 1'b0, 10, 0, 1'b0);
        run_line(32'h4000_0000, 16, 1'b0, 0, 5, 1'b0);

        read_addr = 32'h6000_0000;
        read_num = 32'd0;
        kick = 1'b1;
        @(negedge clk);
        kick = 1'b0;
        repeat (5) begin
            chk("num0_busy", 32'(busy), 32'd0);
            chk("num0_arvalid", 32'(m_arvalid), 32'd0);
            chk("num0_err_kept", 32'(err), 32'd1);
            @(negedge clk);
        end

        run_line(32'h5000_0100, 300, 1'b0, 0, 0, 1'b1);

        start_line(32'h2000_0000, 64, 1'b0, 0, 0, nb);
        t = 0;
        while (we_cnt < 10 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("mid_data_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_rst("async_rst");
        exp_ar.delete();
        exp_data.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_idle", {30'd0, busy, m_arvalid}, 32'd0);
        end
        run_line(32'h2000_0000, 64, 1'b0, 0, 0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] ra = $urandom;
            if (i % 2 == 1) ra[11:0] = 12'hFFF - 12'($urandom_range(0, 200));
            run_line(ra, $urandom_range(1, 600), 1'b0, 0, (i == 2) ? $urandom_range(1, 20) : 0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
